// File: rtl/matrix_slot_pkg.sv
// Shared types and constants for the matrix slot writer.
// Latency: n/a (types, constants and a pure header-packing function).
// Backpressure: n/a.
// Optional feature macro: MATRIX_SLOT_WRITER_CHECKSUM_EN adds a checksum word per slot.
package matrix_slot_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INVAL,
    S_NAME0,
    S_NAME1,
    S_DATA,
    S_CKSUM,
    S_HEADER,
    S_DONE,
    S_ERROR
  } writer_state_t;

  // Word offsets inside a slot.
  localparam int HDR_OFFSET  = 0;
  localparam int NAME_OFFSET = 1;
  localparam int DATA_OFFSET = 3;

  // Header field positions.
  localparam int HDR_ID_LSB    = 24;
  localparam int HDR_ROWS_LSB  = 16;
  localparam int HDR_COLS_LSB  = 8;
  localparam int HDR_VALID_BIT = 0;

  // The checksum occupies the last word of the slot, taking one word of data capacity.
`ifdef MATRIX_SLOT_WRITER_CHECKSUM_EN
  localparam int CKSUM_WORDS = 1;
`else
  localparam int CKSUM_WORDS = 0;
`endif

  function automatic logic [31:0] pack_header(input logic [7:0] id,
                                               input logic [7:0] rows,
                                               input logic [7:0] cols,
                                               input logic       valid);
    logic [31:0] hdr;
    hdr                       = '0;
    hdr[HDR_ID_LSB +: 8]      = id;
    hdr[HDR_ROWS_LSB +: 8]    = rows;
    hdr[HDR_COLS_LSB +: 8]    = cols;
    hdr[HDR_VALID_BIT]        = valid;
    return hdr;
  endfunction

endpackage

// File: rtl/matrix_slot_addr_calc.sv
// Slot base address, element total and capacity check for an incoming request.
// Latency: ok_o is combinational on the request fields; base_o/total_o register on load_i.
// Backpressure: none; load_i is the accept strobe from the writer FSM.
// Ports: clk/rst; load_i, id_i, rows_i, cols_i (request); ok_o, base_o, total_o.
module matrix_slot_addr_calc
  import matrix_slot_pkg::*;
#(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_SLOTS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [2:0]            id_i,
  input  logic [7:0]            rows_i,
  input  logic [7:0]            cols_i,
  output logic                  ok_o,
  output logic [ADDR_WIDTH-1:0] base_o,
  output logic [15:0]           total_o
);

  localparam int CAPACITY = BLOCK_SIZE - DATA_OFFSET - CKSUM_WORDS;

  logic [15:0]           total_d, total_q;
  logic [ADDR_WIDTH-1:0] base_d, base_q;

  assign total_d = 16'(rows_i) * 16'(cols_i);
  assign base_d  = ADDR_WIDTH'(id_i) * ADDR_WIDTH'(BLOCK_SIZE);

  // Passing this check guarantees base + offset never leaves the slot or wraps.
  assign ok_o = (rows_i != 8'd0) && (cols_i != 8'd0) &&
                (int'(id_i) < NUM_SLOTS) && (int'(total_d) <= CAPACITY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q  <= '0;
      total_q <= '0;
    end else if (load_i) begin
      base_q  <= base_d;
      total_q <= total_d;
    end
  end

  assign base_o  = base_q;
  assign total_o = total_q;

endmodule

// File: rtl/matrix_slot_writer.sv
// Commits a result matrix into one BRAM slot: invalid header, name, data, [checksum], valid header.
// Latency: accept cycle + 3 + N + 1 + 1 cycles; each state's BRAM write appears on the registered port one cycle later.
// Backpressure: write_ready high only in DATA; elements offered while it is low are dropped.
// Ports: clk, rst; write_request/_matrix_id/_rows/_cols/_name (request), write_data/_data_valid (elements);
//        writer_ready, write_ready, write_done, write_error (status); bram_wr_en/_addr/_data (BRAM port).
// Optional feature macro: MATRIX_SLOT_WRITER_CHECKSUM_EN (XOR of data words in the slot's last word).
module matrix_slot_writer
  import matrix_slot_pkg::*;
#(
  parameter int BLOCK_SIZE = 1152,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_SLOTS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_request,
  input  logic [2:0]            write_matrix_id,
  input  logic [7:0]            write_rows,
  input  logic [7:0]            write_cols,
  input  logic [0:7][7:0]       write_name,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_data_valid,
  output logic                  writer_ready,
  output logic                  write_ready,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data
);

  writer_state_t         state_q;
  logic                  writer_ready_q, write_ready_q, write_done_q, write_error_q;
  logic                  bram_wr_en_q;
  logic [ADDR_WIDTH-1:0] bram_wr_addr_q;
  logic [DATA_WIDTH-1:0] bram_wr_data_q;
  logic [2:0]            id_q;
  logic [7:0]            rows_q, cols_q;
  logic [0:7][7:0]       name_q;
  logic [15:0]           cnt_q;
`ifdef MATRIX_SLOT_WRITER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cksum_q;
`endif

  logic                  req_accept;
  logic                  req_ok;
  logic [ADDR_WIDTH-1:0] base;
  logic [15:0]           total;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic                  last_elem;
  logic [DATA_WIDTH-1:0] hdr_inval, hdr_valid;

  assign req_accept = (state_q == S_IDLE) && writer_ready_q && write_request;

  matrix_slot_addr_calc #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLOTS  (NUM_SLOTS)
  ) u_addr_calc (
    .clk     (clk),
    .rst     (rst),
    .load_i  (req_accept),
    .id_i    (write_matrix_id),
    .rows_i  (write_rows),
    .cols_i  (write_cols),
    .ok_o    (req_ok),
    .base_o  (base),
    .total_o (total)
  );

  assign data_addr = base + ADDR_WIDTH'(DATA_OFFSET) + ADDR_WIDTH'(cnt_q);
  assign last_elem = (cnt_q == total - 16'd1);
  assign hdr_inval = DATA_WIDTH'(pack_header({5'b0, id_q}, rows_q, cols_q, 1'b0));
  assign hdr_valid = DATA_WIDTH'(pack_header({5'b0, id_q}, rows_q, cols_q, 1'b1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      writer_ready_q <= 1'b1;
      write_ready_q  <= 1'b0;
      write_done_q   <= 1'b0;
      write_error_q  <= 1'b0;
      bram_wr_en_q   <= 1'b0;
      bram_wr_addr_q <= '0;
      bram_wr_data_q <= '0;
      id_q           <= '0;
      rows_q         <= '0;
      cols_q         <= '0;
      name_q         <= '0;
      cnt_q          <= '0;
`ifdef MATRIX_SLOT_WRITER_CHECKSUM_EN
      cksum_q        <= '0;
`endif
    end else begin
      // Strobes default low; each state below raises what it needs for one cycle.
      bram_wr_en_q  <= 1'b0;
      write_done_q  <= 1'b0;
      write_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_accept) begin
            id_q           <= write_matrix_id;
            rows_q         <= write_rows;
            cols_q         <= write_cols;
            name_q         <= write_name;
            cnt_q          <= '0;
`ifdef MATRIX_SLOT_WRITER_CHECKSUM_EN
            cksum_q        <= '0;
`endif
            writer_ready_q <= 1'b0;
            if (req_ok) begin
              state_q <= S_INVAL;
            end else begin
              write_error_q <= 1'b1;
              state_q       <= S_ERROR;
            end
          end
        end
        S_ERROR: begin
          writer_ready_q <= 1'b1;
          state_q        <= S_IDLE;
        end
        S_INVAL: begin
          // Invalidate first so a reader never trusts a half-written slot.
          bram_wr_en_q   <= 1'b1;
          bram_wr_addr_q <= base + ADDR_WIDTH'(HDR_OFFSET);
          bram_wr_data_q <= hdr_inval;
          state_q        <= S_NAME0;
        end
        S_NAME0: begin
          bram_wr_en_q   <= 1'b1;
          bram_wr_addr_q <= base + ADDR_WIDTH'(NAME_OFFSET);
          bram_wr_data_q <= DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
          state_q        <= S_NAME1;
        end
        S_NAME1: begin
          bram_wr_en_q   <= 1'b1;
          bram_wr_addr_q <= base + ADDR_WIDTH'(NAME_OFFSET + 1);
          bram_wr_data_q <= DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});
          write_ready_q  <= 1'b1;
          state_q        <= S_DATA;
        end
        S_DATA: begin
          if (write_data_valid) begin
            bram_wr_en_q   <= 1'b1;
            bram_wr_addr_q <= data_addr;
            bram_wr_data_q <= write_data;
            cnt_q          <= cnt_q + 16'd1;
`ifdef MATRIX_SLOT_WRITER_CHECKSUM_EN
            cksum_q        <= cksum_q ^ write_data;
`endif
            if (last_elem) begin
              write_ready_q <= 1'b0;
`ifdef MATRIX_SLOT_WRITER_CHECKSUM_EN
              state_q       <= S_CKSUM;
`else
              state_q       <= S_HEADER;
`endif
            end
          end
        end
`ifdef MATRIX_SLOT_WRITER_CHECKSUM_EN
        S_CKSUM: begin
          bram_wr_en_q   <= 1'b1;
          bram_wr_addr_q <= base + ADDR_WIDTH'(BLOCK_SIZE - 1);
          bram_wr_data_q <= cksum_q;
          state_q        <= S_HEADER;
        end
`endif
        S_HEADER: begin
          bram_wr_en_q   <= 1'b1;
          bram_wr_addr_q <= base + ADDR_WIDTH'(HDR_OFFSET);
          bram_wr_data_q <= hdr_valid;
          write_done_q   <= 1'b1;
          state_q        <= S_DONE;
        end
        S_DONE: begin
          writer_ready_q <= 1'b1;
          state_q        <= S_IDLE;
        end
        default: begin
          writer_ready_q <= 1'b1;
          write_ready_q  <= 1'b0;
          state_q        <= S_IDLE;
        end
      endcase
    end
  end

  assign writer_ready = writer_ready_q;
  assign write_ready  = write_ready_q;
  assign write_done   = write_done_q;
  assign write_error  = write_error_q;
  assign bram_wr_en   = bram_wr_en_q;
  assign bram_wr_addr = bram_wr_addr_q;
  assign bram_wr_data = bram_wr_data_q;

endmodule
